// File: rtl/addsub_seq.sv
// Multi-cycle 32-bit add/subtract, CHUNK_W bits per cycle through a registered ripple carry.
// Latency: start accepted at edge T, done pulses in the cycle after edge T+N (N = 32/CHUNK_W).
// Backpressure: start is honoured only in IDLE or DONE; starts while busy are dropped, not queued.
// Optional feature macro ADDSUB_OVF_EN: registers signed overflow and signed less-than flags.
module addsub_seq #(
  parameter int CHUNK_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        zf,
  output logic        nz,
  output logic        cout,
  output logic        ovf,
  output logic        lt
);

  localparam int N  = 32 / CHUNK_W;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam logic [31:0] CHUNK_MASK = 32'((64'd1 << CHUNK_W) - 64'd1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;      // already inverted for subtraction
  logic [31:0]     res_q, res_d;
  logic            carry_q, carry_d;
  logic [KW-1:0]   k_q, k_d;
  logic            zf_q, zf_d;
  logic            nz_q, nz_d;
  logic            cout_q, cout_d;

  logic [31:0]        sh;
  logic [CHUNK_W-1:0] a_chunk, b_chunk;
  logic [CHUNK_W:0]   chunk_sum;
  logic [31:0]        res_run;
  logic               last_chunk;
  logic               finishing;

  // Chunk adder: select chunk k of both operands and splice the sum back into the result.
  always_comb begin
    sh         = 32'(k_q) * 32'(CHUNK_W);
    a_chunk    = CHUNK_W'(a_q >> sh);
    b_chunk    = CHUNK_W'(b_q >> sh);
    chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + (CHUNK_W+1)'(carry_q);
    res_run    = (res_q & ~(CHUNK_MASK << sh)) | (32'(chunk_sum[CHUNK_W-1:0]) << sh);
    last_chunk = (k_q == KW'(N - 1));
    finishing  = (state_q == RUN) && last_chunk;
  end

  // Next-state and datapath update; everything holds unless the FSM says otherwise.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    k_d     = k_q;
    zf_d    = zf_q;
    nz_d    = nz_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub;           // +1 completes the two's complement of b
          k_d     = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        res_d   = res_run;
        carry_d = chunk_sum[CHUNK_W];
        if (last_chunk) begin
          // Flags only move here so they stay stable while chunks are in flight.
          cout_d  = chunk_sum[CHUNK_W];
          zf_d    = (res_run == 32'd0);
          nz_d    = (res_run != 32'd0);
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      zf_q    <= 1'b0;
      nz_q    <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      zf_q    <= zf_d;
      nz_q    <= nz_d;
      cout_q  <= cout_d;
    end
  end

`ifdef ADDSUB_OVF_EN
  logic ovf_q, lt_q;
  logic ovf_now;

  assign ovf_now = (a_q[31] == b_q[31]) && (res_run[31] != a_q[31]);

  // Signed overflow and signed less-than, captured with the other flags on the last chunk.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      lt_q  <= 1'b0;
    end else if (finishing) begin
      ovf_q <= ovf_now;
      lt_q  <= res_run[31] ^ ovf_now;
    end
  end

  assign ovf = ovf_q;
  assign lt  = lt_q;
`else
  assign ovf = 1'b0;
  assign lt  = 1'b0;
`endif

  assign busy   = (state_q == RUN);
  assign done   = (state_q == DONE);
  assign result = res_q;
  assign zf     = zf_q;
  assign nz     = nz_q;
  assign cout   = cout_q;

endmodule
